// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the select of an 8:1 mux shared by eight requesters.
// One requester is granted at a time and sel is held for the whole grant.
// Every grant is followed by one dead GAP cycle before arbitration resumes.
// Optional feature macro: ARB_TIMEOUT_EN. When defined, it caps each grant at
// MAX_HOLD cycles and pulses tmo on revocation.
module mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       tmo
);

  localparam int unsigned N  = 8;
  localparam int unsigned SW = 3;
`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = 8;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic            busy_q, busy_d;
  logic            tmo_q, tmo_d;
  logic [SW-1:0]   ptr_q, ptr_d;
`ifdef ARB_TIMEOUT_EN
  logic [CW-1:0]   hold_q, hold_d;
`endif

  logic            found;
  logic [SW-1:0]   winner;
  logic [SW-1:0]   idx;

  // Rotating priority search: first set request at or above ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    idx    = ptr_q;
    for (int k = 0; k < int'(N); k++) begin
      idx = ptr_q + SW'(k);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    tmo_d   = 1'b0;
    ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
    hold_d  = hold_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_GRANT;
          gnt_d   = N'(1) << winner;
          sel_d   = winner;
          busy_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      S_GRANT: begin
        if (!req[sel_q]) begin
          state_d = S_GAP;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = sel_q + SW'(1);
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == CW'(MAX_HOLD - 1)) begin
          state_d = S_GAP;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = sel_q + SW'(1);
          tmo_d   = 1'b1;
        end else begin
          hold_d  = hold_q + CW'(1);
        end
`endif
      end
      S_GAP: begin
        // sel keeps its last value so the mux output stays quiet.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      ptr_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
      ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;
  assign tmo  = tmo_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus random requests, with
// expected outputs from a behavioural model queued and checked by a monitor.
module tb_mux_rr_arbiter;

  localparam int unsigned HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       tmo;

  int tests = 0;
  int fails = 0;

  mux_rr_arbiter #(.MAX_HOLD(HOLD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .gnt  (gnt),
    .sel  (sel),
    .busy (busy),
    .tmo  (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: owner index (-1 when none), gap/idle phase, pointer.
  int m_owner;     // -1: no grant
  int m_gap;       // 1 during the dead cycle after a grant
  int m_ptr;
  int m_len;       // cycles the current grant has been held
  int m_last_sel;
  int m_tmo;

  logic [12:0] sbq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [12:0] model_out();
    logic [7:0] g;
    g = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
    return {g, 3'(m_last_sel), (m_owner >= 0) ? 1'b1 : 1'b0, 1'(m_tmo)};
  endfunction

  task automatic model_reset();
    m_owner = -1; m_gap = 0; m_ptr = 0; m_len = 0; m_last_sel = 0; m_tmo = 0;
  endtask

  task automatic model_step(input logic [7:0] r);
    bit revoke;
    m_tmo = 0;
    if (m_gap != 0) begin
      m_gap = 0;
    end else if (m_owner < 0) begin
      if (r != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          if (m_owner < 0 && r[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
        end
        m_last_sel = m_owner;
        m_len = 1;
      end
    end else begin
      revoke = 0;
`ifdef ARB_TIMEOUT_EN
      revoke = (m_len >= int'(HOLD));
`endif
      if (!r[m_owner] || revoke) begin
        m_ptr   = (m_owner + 1) % 8;
        m_tmo   = (r[m_owner] && revoke) ? 1 : 0;
        m_owner = -1;
        m_gap   = 1;
      end else begin
        m_len++;
      end
    end
  endtask

  // One clock of stimulus: drive req, let the edge happen, queue the expectation.
  task automatic step(input logic [7:0] r);
    req = r;
    @(posedge clk);
    #1;
    model_step(r);
    sbq.push_back(model_out());
    @(negedge clk);
  endtask

  // Monitor: compares DUT outputs against queued expectations on the falling edge.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      logic [12:0] e;
      e = sbq.pop_front();
      check("scoreboard{gnt,sel,busy,tmo}", {19'd0, gnt, sel, busy, tmo}, {19'd0, e});
    end
  end

  initial begin
    logic [7:0] r;
    model_reset();
    rst_n = 1'b0;
    req   = 8'hFF;
    #12;
    check("reset gnt",  32'(gnt),  32'h00);
    check("reset sel",  32'(sel),  32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset tmo",  32'(tmo),  32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(8'h01);
    check("first grant gnt", 32'(gnt), 32'h01);
    check("first grant sel", 32'(sel), 32'd0);
    step(8'h00);
    step(8'h00);

    // Round robin from a fresh pointer.
    @(negedge clk); #2 rst_n = 1'b0; model_reset();
    @(negedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step(8'hFF);
      check("rr sel", 32'(sel), 32'(i % 8));
      step(8'hFF);
      r = 8'hFF & ~(8'h01 << (i % 8));
      step(r);
      check("rr gap gnt", 32'(gnt), 32'h00);
      step(8'hFF);
      check("rr idle gnt", 32'(gnt), 32'h00);
    end
    step(8'h00);
    step(8'h00);

    // Wrap and skip: ptr forced to 6 via index 5.
    step(8'h20);
    check("skip grant5", 32'(sel), 32'd5);
    step(8'h00);
    step(8'h00);
    step(8'h05);
    check("wrap grant0", 32'(sel), 32'd0);
    step(8'h04);
    step(8'h04);
    step(8'h04);
    check("skip grant2", 32'(sel), 32'd2);
    step(8'h00);
    step(8'h00);

    // No preemption while other requesters toggle.
    step(8'h08);
    for (int i = 0; i < 10; i++) begin
      step((i % 2 == 0) ? 8'hFF : 8'h08);
      if (i < 2) begin
        check("nopreempt sel", 32'(sel), 32'd3);
        check("nopreempt gnt", 32'(gnt), 32'h08);
      end
    end
    step(8'h00);
    step(8'h00);
    step(8'h00);

    // Async reset mid-grant.
    step(8'h10);
    step(8'h10);
    check("pre-reset gnt", 32'(gnt), 32'h10);
    #2 rst_n = 1'b0;
    #1;
    check("async rst gnt",  32'(gnt),  32'h00);
    check("async rst busy", 32'(busy), 32'd0);
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(8'h10);
    check("post-reset grant4", 32'(gnt), 32'h10);
    step(8'h00);
    step(8'h00);

    // Timeout behaviour with two contending requesters.
    @(negedge clk); #2 rst_n = 1'b0; model_reset();
    @(negedge clk); #2 rst_n = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      step(8'h06);
`ifdef ARB_TIMEOUT_EN
      if (i == 4) check("tmo last grant cycle", 32'(gnt), 32'h02);
      if (i == 5) check("tmo pulse", 32'(tmo), 32'd1);
      if (i == 6) check("tmo single", 32'(tmo), 32'd0);
      if (i == 7) check("tmo next grant2", 32'(sel), 32'd2);
      if (i == 13) check("tmo back to 1", 32'(sel), 32'd1);
`else
      if (i == 5 || i == 14) check("hold index1", 32'(gnt), 32'h02);
      if (i == 14) check("no tmo", 32'(tmo), 32'd0);
`endif
    end
    step(8'h00);
    step(8'h00);

    // Random requests against the model.
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 3))
        0:       r = 8'h00;
        1:       r = 8'($urandom);
        default: r = 8'($urandom) & 8'($urandom);
      endcase
      step(r);
    end

    step(8'h00);
    @(negedge clk);
    check("scoreboard drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
